// File: rtl/mem_access_stage.sv
// MEM pipeline stage: launches loads/stores on a req/ack data bus, stalls upstream while busy,
// and feeds the MEM/WB register. Define MEM_TIMEOUT_EN to abort stuck accesses after TIMEOUT_CYCLES.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ctrls_m,
    input  logic [31:0] aluout_m,
    input  logic [31:0] write_data_m,
    input  logic [4:0]  writereg_m,
    output logic        stall_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  ctrls_w,
    output logic [31:0] aluout_w,
    output logic [31:0] readdata_w,
    output logic [4:0]  writereg_w,
    output logic        bus_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_next;
    logic   mem_op;
    logic   launch;
    logic   complete;
    logic   timeout_hit;
    logic   stall_raw;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

    assign mem_op = ctrls_m[1] | ctrls_m[0];

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches inferred.
        state_next = state;
        stall_raw  = 1'b0;
        launch     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall_raw  = 1'b1;
                    launch     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Upstream is never held while this stage is in reset.
    assign stall_m = stall_raw & reset;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          tmo_cnt <= 8'd0;
        else if (launch)                     tmo_cnt <= 8'd0;
        else if (state == BUSY && !dmem_ack) tmo_cnt <= tmo_cnt + 8'd1;
    end

    // Last waiting cycle: the instruction retires with a zeroed result instead of stalling.
    assign timeout_hit = (state == BUSY) && !dmem_ack && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           bus_err <= 1'b0;
        else if (timeout_hit) bus_err <= 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            ctrls_w    <= 2'b00;
            aluout_w   <= 32'd0;
            readdata_w <= 32'd0;
            writereg_w <= 5'd0;
        end else begin
            if (launch) begin
                dmem_addr  <= aluout_m;
                dmem_wdata <= write_data_m;
                dmem_we    <= ctrls_m[0];
                dmem_req   <= 1'b1;
            end
            if (complete) begin
                dmem_req <= 1'b0;
                if (!dmem_we) readdata_w <= dmem_rdata;
            end
            if (timeout_hit) begin
                dmem_req   <= 1'b0;
                readdata_w <= 32'd0;
            end
            if (stall_m) begin
                ctrls_w <= 2'b00;
            end else begin
                ctrls_w    <= ctrls_m[2:1];
                aluout_w   <= aluout_m;
                writereg_w <= writereg_m;
            end
        end
    end

endmodule
